// File: rtl/pe_ctx_pkg.sv
// Shared definitions for the pe_ctx processing element: context word layout,
// routing source codes and FU opcodes.
package pe_ctx_pkg;

  localparam int INST_W = 35;
  localparam int FLD_W  = 4;

  // Bit positions inside a context word
  localparam int OPC_LSB   = 31;
  localparam int SRCA_LSB  = 27;
  localparam int SRCB_LSB  = 23;
  localparam int OUTN_LSB  = 19;
  localparam int OUTS_LSB  = 15;
  localparam int OUTW_LSB  = 11;
  localparam int OUTE_LSB  = 7;
  localparam int RFWE_BIT  = 6;
  localparam int RFWA_LSB  = 4;
  localparam int RFSRC_LSB = 0;

  // Codes 9..15 select constant zero
  typedef enum logic [3:0] {
    SRC_N, SRC_S, SRC_W, SRC_E,
    SRC_R0, SRC_R1, SRC_R2, SRC_R3,
    SRC_RES
  } src_e;

  typedef enum logic [3:0] {
    OP_PASS, OP_ADD, OP_SUB, OP_MUL,
    OP_AND, OP_OR, OP_XOR,
    OP_SHL, OP_SHR, OP_SRA,
    OP_SLT, OP_EQ, OP_MIN, OP_MAX
  } opcode_e;

endpackage

// File: rtl/pe_ctx_fu.sv
// Combinational functional unit of the PE; opcodes 14..15 yield zero.
module pe_ctx_fu
  import pe_ctx_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] res
);

  localparam int SW = $clog2(DW);

  logic [SW-1:0] sh;
  logic          lt;

  assign sh = b[SW-1:0];
  assign lt = $signed(a) < $signed(b);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    res = '0;
    case (op)
      OP_PASS: res = a;
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_MUL:  res = a * b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL:  res = a << sh;
      OP_SHR:  res = a >> sh;
      OP_SRA:  res = $unsigned($signed(a) >>> sh);
      OP_SLT:  res = {{(DW-1){1'b0}}, lt};
      OP_EQ:   res = {{(DW-1){1'b0}}, a == b};
      OP_MIN:  res = lt ? a : b;
      OP_MAX:  res = lt ? b : a;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/pe_ctx.sv
// CGRA processing element: serially loaded context buffer replayed cyclically,
// with per-context routing, one register-file write and one FU operation.
module pe_ctx
  import pe_ctx_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INST_W-1:0]        PE_inst,
  input  logic                     init,
  input  logic                     run,
  input  logic                     stall,
  input  logic                     cfg_clr,
  input  logic [DW-1:0]            din_N,
  input  logic [DW-1:0]            din_S,
  input  logic [DW-1:0]            din_W,
  input  logic [DW-1:0]            din_E,
  output logic [DW-1:0]            dout_N,
  output logic [DW-1:0]            dout_S,
  output logic [DW-1:0]            dout_W,
  output logic [DW-1:0]            dout_E,
  output logic [$clog2(DEPTH):0]   ctx_cnt,
  output logic                     cfg_overflow,
  output logic                     iter_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [INST_W-1:0] ctx_buf [DEPTH];
  logic [INST_W-1:0] inst_r;
  logic              inst_valid;
  logic [AW-1:0]     pc;
  logic [DW-1:0]     res;
  logic [DW-1:0]     rf [4];
  logic [DW-1:0]     src_val [16];
  logic [DW-1:0]     fu_res;
  logic              exec;
  logic              last;

  assign exec = inst_valid && !stall;
  assign last = ({1'b0, pc} == ctx_cnt - (AW+1)'(1));

  always_comb begin
    for (int i = 0; i < 16; i++) src_val[i] = '0;
    src_val[SRC_N]   = din_N;
    src_val[SRC_S]   = din_S;
    src_val[SRC_W]   = din_W;
    src_val[SRC_E]   = din_E;
    src_val[SRC_R0]  = rf[0];
    src_val[SRC_R1]  = rf[1];
    src_val[SRC_R2]  = rf[2];
    src_val[SRC_R3]  = rf[3];
    src_val[SRC_RES] = res;
  end

  // Routing is zero-latency from din; an idle PE drives zeros on every port.
  assign dout_N = inst_valid ? src_val[inst_r[OUTN_LSB +: FLD_W]] : '0;
  assign dout_S = inst_valid ? src_val[inst_r[OUTS_LSB +: FLD_W]] : '0;
  assign dout_W = inst_valid ? src_val[inst_r[OUTW_LSB +: FLD_W]] : '0;
  assign dout_E = inst_valid ? src_val[inst_r[OUTE_LSB +: FLD_W]] : '0;

  pe_ctx_fu #(.DW(DW)) u_fu (
    .op  (inst_r[OPC_LSB +: FLD_W]),
    .a   (src_val[inst_r[SRCA_LSB +: FLD_W]]),
    .b   (src_val[inst_r[SRCB_LSB +: FLD_W]]),
    .res (fu_res)
  );

  // NOTE: state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctx_cnt      <= '0;
      pc           <= '0;
      inst_r       <= '0;
      inst_valid   <= 1'b0;
      res          <= '0;
      cfg_overflow <= 1'b0;
      iter_done    <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      // NOTE: the context buffer is cleared on reset, so it is built from flops, not RAM.
      for (int i = 0; i < DEPTH; i++) ctx_buf[i] <= '0;
    end else begin
      iter_done <= 1'b0;

      // Execute stage: the context fetched on the previous edge.
      if (exec) begin
        res <= fu_res;
        if (inst_r[RFWE_BIT])
          rf[inst_r[RFWA_LSB +: 2]] <= src_val[inst_r[RFSRC_LSB +: FLD_W]];
      end

      if (cfg_clr) begin
        ctx_cnt    <= '0;
        pc         <= '0;
        inst_valid <= 1'b0;
      end else if (init) begin
        inst_valid <= 1'b0;
        if (ctx_cnt < FULL) begin
          ctx_buf[ctx_cnt[AW-1:0]] <= PE_inst;
          ctx_cnt                  <= ctx_cnt + (AW+1)'(1);
        end else begin
          cfg_overflow <= 1'b1;
        end
      end else if (run) begin
        if (ctx_cnt != '0 && !stall) begin
          inst_r     <= ctx_buf[pc];
          inst_valid <= 1'b1;
          pc         <= last ? '0 : pc + AW'(1);
          iter_done  <= last;
        end
      end else begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_ctx.sv
// Self-checking bench for pe_ctx: FU vector table, hand-written corner sequences
// and a randomized run against a behavioural reference model.
module tb_pe_ctx;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, init, run, stall, cfg_clr;
  logic [34:0]   PE_inst;
  logic [DW-1:0] din_N, din_S, din_W, din_E;
  logic [DW-1:0] dout_N, dout_S, dout_W, dout_E;
  logic [4:0]    ctx_cnt;
  logic          cfg_overflow, iter_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pe_ctx #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .PE_inst(PE_inst), .init(init), .run(run),
    .stall(stall), .cfg_clr(cfg_clr),
    .din_N(din_N), .din_S(din_S), .din_W(din_W), .din_E(din_E),
    .dout_N(dout_N), .dout_S(dout_S), .dout_W(dout_W), .dout_E(dout_E),
    .ctx_cnt(ctx_cnt), .cfg_overflow(cfg_overflow), .iter_done(iter_done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [34:0] mk(input logic [3:0] op, sa, sb, on, os, ow, oe,
                                     input logic we, input logic [1:0] wa,
                                     input logic [3:0] rs);
    return {op, sa, sb, on, os, ow, oe, we, wa, rs};
  endfunction

  task automatic do_reset();
    rst = 1'b1; init = 1'b0; run = 1'b0; stall = 1'b0; cfg_clr = 1'b0;
    PE_inst = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [34:0] w);
    init = 1'b1; PE_inst = w;
    tick();
    init = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [34:0] m_buf [DEPTH];
  int          m_cnt, m_pc;
  logic [34:0] m_cur;
  bit          m_valid, m_ovf, m_iter;
  logic [31:0] m_res;
  logic [31:0] m_r [4];

  function automatic logic [31:0] m_src(input logic [3:0] code);
    if (code <= 3) return (code == 0) ? din_N : (code == 1) ? din_S : (code == 2) ? din_W : din_E;
    if (code <= 7) return m_r[code - 4];
    if (code == 8) return m_res;
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, b);
    int sa = $signed(a);
    int sb = $signed(b);
    int sh = int'(b % 32);
    case (op)
      0:  return a;
      1:  return a + b;
      2:  return a - b;
      3:  return a * b;
      4:  return a & b;
      5:  return a | b;
      6:  return a ^ b;
      7:  return a << sh;
      8:  return a >> sh;
      9:  return sa >>> sh;
      10: return (sa < sb) ? 32'd1 : 32'd0;
      11: return (a == b) ? 32'd1 : 32'd0;
      12: return (sa < sb) ? a : b;
      13: return (sa < sb) ? b : a;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_cnt = 0; m_pc = 0; m_cur = '0; m_valid = 0; m_ovf = 0; m_iter = 0; m_res = '0;
    for (int i = 0; i < 4; i++) m_r[i] = '0;
    for (int i = 0; i < DEPTH; i++) m_buf[i] = '0;
  endtask

  // Applies one clock edge using the inputs that were present before it.
  task automatic m_step();
    logic [31:0] a, b, wv;
    if (rst) begin
      m_reset();
      return;
    end
    a  = m_src(m_cur[30:27]);
    b  = m_src(m_cur[26:23]);
    wv = m_src(m_cur[3:0]);
    m_iter = 0;
    if (m_valid && !stall) begin
      m_res = m_alu(m_cur[34:31], a, b);
      if (m_cur[6]) m_r[m_cur[5:4]] = wv;
    end
    if (cfg_clr) begin
      m_cnt = 0; m_pc = 0; m_valid = 0;
    end else if (init) begin
      m_valid = 0;
      if (m_cnt < DEPTH) begin
        m_buf[m_cnt] = PE_inst;
        m_cnt++;
      end else m_ovf = 1;
    end else if (run) begin
      if (m_cnt != 0 && !stall) begin
        m_cur   = m_buf[m_pc];
        m_valid = 1;
        m_iter  = (m_pc == m_cnt - 1);
        m_pc    = (m_pc + 1) % m_cnt;
      end
    end else m_valid = 0;
  endtask

  // ---------------- FU vector table ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[$];
  logic [31:0] exp_n [3];
  logic [63:0] rnd;

  initial begin
    vecs.push_back('{4'd1,  32'd5,          32'd7,          32'd12});
    vecs.push_back('{4'd0,  32'h12345678,   32'd1,          32'h12345678});
    vecs.push_back('{4'd1,  32'hFFFFFFFF,   32'd2,          32'd1});
    vecs.push_back('{4'd2,  32'd3,          32'd5,          32'hFFFFFFFE});
    vecs.push_back('{4'd3,  32'h80000001,   32'd3,          32'h80000003});
    vecs.push_back('{4'd4,  32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000});
    vecs.push_back('{4'd5,  32'hF0F0F0F0,   32'hFF00FF00,   32'hFFF0FFF0});
    vecs.push_back('{4'd6,  32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0});
    vecs.push_back('{4'd7,  32'd1,          32'd33,         32'd2});
    vecs.push_back('{4'd8,  32'h80000000,   32'd4,          32'h08000000});
    vecs.push_back('{4'd9,  32'h80000000,   32'd4,          32'hF8000000});
    vecs.push_back('{4'd10, 32'hFFFFFFFF,   32'd1,          32'd1});
    vecs.push_back('{4'd10, 32'd1,          32'hFFFFFFFF,   32'd0});
    vecs.push_back('{4'd11, 32'd7,          32'd7,          32'd1});
    vecs.push_back('{4'd11, 32'd7,          32'd8,          32'd0});
    vecs.push_back('{4'd12, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF});
    vecs.push_back('{4'd13, 32'hFFFFFFFF,   32'd1,          32'd1});
    vecs.push_back('{4'd14, 32'd5,          32'd7,          32'd0});
    vecs.push_back('{4'd15, 32'd5,          32'd7,          32'd0});

    din_N = 32'h1111; din_S = 32'h2222; din_W = 32'h3333; din_E = 32'h4444;

    // Reset and idle
    do_reset();
    tick();
    check("reset_dout_N", dout_N, 0);
    check("reset_dout_S", dout_S, 0);
    check("reset_dout_W", dout_W, 0);
    check("reset_dout_E", dout_E, 0);
    check("reset_ctx_cnt", 32'(ctx_cnt), 0);
    check("reset_overflow", 32'(cfg_overflow), 0);
    check("reset_iter_done", 32'(iter_done), 0);

    // Single-context FU table: A=din_N, B=din_W, result routed to E
    foreach (vecs[i]) begin
      do_reset();
      load(mk(vecs[i].op, 4'd0, 4'd2, 4'd9, 4'd9, 4'd9, 4'd8, 1'b0, 2'd0, 4'd0));
      din_N = vecs[i].a; din_W = vecs[i].b; run = 1'b1;
      tick();
      check($sformatf("fu%0d_iter_fetch", i), 32'(iter_done), 1);
      tick();
      check($sformatf("fu%0d_op%0d_dout_E", i, vecs[i].op), dout_E, vecs[i].exp);
      check($sformatf("fu%0d_iter_next", i), 32'(iter_done), 1);
      run = 1'b0;
      tick();
    end

    // Three contexts: wrap at ctx_cnt, iter_done every third fetch
    do_reset();
    for (int i = 0; i < 3; i++)
      load(mk(4'd0, 4'd9, 4'd9, 4'(i), 4'd9, 4'd9, 4'd9, 1'b0, 2'd0, 4'd0));
    check("wrap_ctx_cnt", 32'(ctx_cnt), 3);
    din_N = 32'h100; din_S = 32'h200; din_W = 32'h300;
    exp_n[0] = 32'h100; exp_n[1] = 32'h200; exp_n[2] = 32'h300;
    run = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("wrap_fetch%0d", k), dout_N, exp_n[(k-1) % 3]);
      check($sformatf("wrap_iter%0d", k), 32'(iter_done), (k % 3 == 0) ? 1 : 0);
    end
    run = 1'b0;

    // Overflow: only word DEPTH lands in the last slot
    do_reset();
    for (int j = 1; j <= DEPTH + 2; j++)
      load(mk(4'd0, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9,
              (j == DEPTH) ? 4'd0 : (j > DEPTH) ? 4'd1 : 4'd9, 1'b0, 2'd0, 4'd0));
    check("ovf_ctx_cnt", 32'(ctx_cnt), DEPTH);
    check("ovf_flag", 32'(cfg_overflow), 1);
    din_N = 32'hAAAA; din_S = 32'h5555; run = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      if (k == DEPTH - 1) check("ovf_iter_before_last", 32'(iter_done), 0);
      if (k == DEPTH) begin
        check("ovf_last_slot", dout_E, 32'hAAAA);
        check("ovf_iter_last", 32'(iter_done), 1);
      end
    end
    run = 1'b0;
    cfg_clr = 1'b1; tick(); cfg_clr = 1'b0;
    check("clr_keeps_overflow", 32'(cfg_overflow), 1);
    check("clr_ctx_cnt", 32'(ctx_cnt), 0);

    // Register file path and stall
    do_reset();
    load(mk(4'd1, 4'd0, 4'd2, 4'd9, 4'd9, 4'd9, 4'd8, 1'b1, 2'd2, 4'd1));
    load(mk(4'd0, 4'd9, 4'd9, 4'd6, 4'd9, 4'd9, 4'd8, 1'b0, 2'd0, 4'd0));
    din_N = 32'd3; din_W = 32'd4; din_S = 32'hA5; run = 1'b1;
    tick();
    check("rf_ctx0_dout_N", dout_N, 0);
    check("rf_ctx0_dout_E", dout_E, 0);
    tick();
    check("rf_ctx1_dout_N", dout_N, 32'hA5);
    check("rf_ctx1_dout_E", dout_E, 32'd7);
    check("rf_ctx1_iter", 32'(iter_done), 1);
    stall = 1'b1; din_S = 32'h11; din_N = 32'd100;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall%0d_dout_N", k), dout_N, 32'hA5);
      check($sformatf("stall%0d_dout_E", k), dout_E, 32'd7);
      check($sformatf("stall%0d_iter", k), 32'(iter_done), 0);
    end
    stall = 1'b0; din_N = 32'd3;
    tick();
    check("resume_ctx0_dout_N", dout_N, 0);
    check("resume_ctx0_dout_E", dout_E, 0);
    tick();
    check("resume_ctx1_dout_N", dout_N, 32'h11);
    check("resume_ctx1_dout_E", dout_E, 32'd7);
    check("resume_ctx1_iter", 32'(iter_done), 1);

    // cfg_clr during run, then run is ignored
    cfg_clr = 1'b1; tick(); cfg_clr = 1'b0;
    check("clr_run_dout_N", dout_N, 0);
    check("clr_run_dout_E", dout_E, 0);
    check("clr_run_ctx_cnt", 32'(ctx_cnt), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("clr_idle%0d_dout_N", k), dout_N, 0);
      check($sformatf("clr_idle%0d_iter", k), 32'(iter_done), 0);
    end
    run = 1'b0;

    // rst mid-run
    din_N = 32'hBEEF;
    for (int j = 0; j <= DEPTH; j++)
      load(mk(4'd0, 4'd9, 4'd9, 4'd0, 4'd9, 4'd9, 4'd9, 1'b0, 2'd0, 4'd0));
    run = 1'b1;
    tick(); tick();
    check("prerst_dout_N", dout_N, 32'hBEEF);
    check("prerst_overflow", 32'(cfg_overflow), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_dout_N", dout_N, 0);
    check("rst_ctx_cnt", 32'(ctx_cnt), 0);
    check("rst_overflow", 32'(cfg_overflow), 0);
    check("rst_iter", 32'(iter_done), 0);
    tick();
    check("rst_run_ignored", dout_N, 0);
    run = 1'b0;

    // Randomized run against the reference model
    do_reset();
    m_reset();
    for (int c = 0; c < 2000; c++) begin
      int r = $urandom_range(0, 99);
      rst = (r == 0); cfg_clr = (r >= 1 && r <= 2); init = (r >= 3 && r <= 14);
      run = ($urandom_range(0, 99) < 85); stall = ($urandom_range(0, 99) < 20);
      rnd = {$urandom, $urandom}; PE_inst = rnd[34:0];
      din_N = $urandom; din_S = $urandom;
      din_W = ($urandom_range(0, 3) == 0) ? din_N : $urandom;
      din_E = $urandom_range(0, 40);
      #1;
      check("rand_dout_N", dout_N, m_valid ? m_src(m_cur[22:19]) : 32'd0);
      check("rand_dout_S", dout_S, m_valid ? m_src(m_cur[18:15]) : 32'd0);
      check("rand_dout_W", dout_W, m_valid ? m_src(m_cur[14:11]) : 32'd0);
      check("rand_dout_E", dout_E, m_valid ? m_src(m_cur[10:7]) : 32'd0);
      check("rand_ctx_cnt", 32'(ctx_cnt), 32'(m_cnt));
      check("rand_overflow", 32'(cfg_overflow), 32'(m_ovf));
      check("rand_iter", 32'(iter_done), 32'(m_iter));
      @(posedge clk);
      m_step();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
